// File: rtl/if_fetch.sv
// Instruction fetch stage: one outstanding imem read, IF/ID output register and one-entry skid buffer.
// Define IF_ALIGN_CHECK_EN to trap misaligned redirect targets (sticky o_IF_misalign, fetch halts).
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_EXIF_jump,
  input  logic [31:0] i_EXIF_target,
  input  logic        i_IFID_stall,
  output logic        o_IFID_valid,
  output logic [31:0] o_IFID_pc,
  output logic [31:0] o_IFID_inst,
  output logic        o_IF_misalign
);

  typedef enum logic [2:0] {
    S_REQ,
    S_WAIT,
    S_KILL,
    S_FULL,
    S_HALT
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] skid_pc;
  logic [31:0] skid_inst;
  logic        misalign_q;
  logic [31:0] jump_target;
  logic        jump_misalign;

`ifdef IF_ALIGN_CHECK_EN
  assign jump_target   = i_EXIF_target;
  assign jump_misalign = |i_EXIF_target[1:0];
`else
  logic unused_target_lsb;
  assign unused_target_lsb = ^i_EXIF_target[1:0];
  assign jump_target       = {i_EXIF_target[31:2], 2'b00};
  assign jump_misalign     = 1'b0;
`endif

  // Gated by rst_n so no request escapes while reset is still held.
  assign o_imem_req    = rst_n && (state == S_REQ);
  assign o_imem_addr   = fetch_pc;
  assign o_IF_misalign = misalign_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_REQ;
      fetch_pc     <= RESET_PC;
      o_IFID_valid <= 1'b0;
      o_IFID_pc    <= '0;
      o_IFID_inst  <= '0;
      skid_pc      <= '0;
      skid_inst    <= '0;
      misalign_q   <= 1'b0;
    end else if (state == S_HALT) begin
      state <= S_HALT;
    end else if (i_EXIF_jump) begin
      o_IFID_valid <= 1'b0;
      skid_pc      <= '0;
      skid_inst    <= '0;
      if (jump_misalign) begin
        misalign_q <= 1'b1;
        state      <= S_HALT;
      end else begin
        fetch_pc <= jump_target;
        // An unanswered request must still be drained before refetching.
        if ((state == S_WAIT || state == S_KILL) && !i_imem_ack)
          state <= S_KILL;
        else
          state <= S_REQ;
      end
    end else begin
      if (o_IFID_valid && !i_IFID_stall)
        o_IFID_valid <= 1'b0;
      case (state)
        S_REQ: state <= S_WAIT;
        S_WAIT: begin
          if (i_imem_ack) begin
            if (!o_IFID_valid || !i_IFID_stall) begin
              o_IFID_valid <= 1'b1;
              o_IFID_pc    <= fetch_pc;
              o_IFID_inst  <= i_imem_rdata;
              fetch_pc     <= fetch_pc + 32'd4;
              state        <= S_REQ;
            end else begin
              skid_pc   <= fetch_pc;
              skid_inst <= i_imem_rdata;
              state     <= S_FULL;
            end
          end
        end
        S_KILL: begin
          if (i_imem_ack)
            state <= S_REQ;
        end
        S_FULL: begin
          if (!i_IFID_stall) begin
            o_IFID_valid <= 1'b1;
            o_IFID_pc    <= skid_pc;
            o_IFID_inst  <= skid_inst;
            fetch_pc     <= fetch_pc + 32'd4;
            state        <= S_REQ;
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: stimulus pushes expected IF/ID words, a monitor pops them on consumption.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic        i_EXIF_jump;
  logic [31:0] i_EXIF_target;
  logic        i_IFID_stall;
  logic        o_IFID_valid;
  logic [31:0] o_IFID_pc;
  logic [31:0] o_IFID_inst;
  logic        o_IF_misalign;

  logic        hi_req;
  logic [31:0] hi_addr;
  logic        hi_ack = 1'b0;
  logic [31:0] hi_rdata = '0;
  logic        hi_valid;
  logic [31:0] hi_pc;
  logic [31:0] hi_inst;
  logic        hi_misalign;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int          cyc = 0;
  int          lat = 1;
  logic [31:0] exp_q[$];
  logic [31:0] hi_exp [3];
  int          hi_idx = 0;

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_ack(i_imem_ack), .i_imem_rdata(i_imem_rdata),
    .i_EXIF_jump(i_EXIF_jump), .i_EXIF_target(i_EXIF_target),
    .i_IFID_stall(i_IFID_stall),
    .o_IFID_valid(o_IFID_valid), .o_IFID_pc(o_IFID_pc), .o_IFID_inst(o_IFID_inst),
    .o_IF_misalign(o_IF_misalign)
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_hi (
    .clk(clk), .rst_n(rst_n),
    .o_imem_req(hi_req), .o_imem_addr(hi_addr),
    .i_imem_ack(hi_ack), .i_imem_rdata(hi_rdata),
    .i_EXIF_jump(1'b0), .i_EXIF_target(32'h0000_0000),
    .i_IFID_stall(1'b0),
    .o_IFID_valid(hi_valid), .o_IFID_pc(hi_pc), .o_IFID_inst(hi_inst),
    .o_IF_misalign(hi_misalign)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int k);
    while (cyc < k) tick();
  endtask

  // Main memory: answers each request 'lat' cycles later; a pending answer survives reset.
  initial begin
    bit          pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = '0;
    forever begin
      @(negedge clk);
      i_imem_ack = 1'b0;
      if (pend) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          i_imem_ack   = 1'b1;
          i_imem_rdata = inst_of(paddr);
          pend         = 1'b0;
        end
      end
      if (o_imem_req === 1'b1) begin
        pend  = 1'b1;
        paddr = o_imem_addr;
        cnt   = lat;
      end
    end
  end

  // Secondary memory: fixed one-cycle latency.
  initial begin
    bit          pend = 1'b0;
    logic [31:0] paddr = '0;
    forever begin
      @(negedge clk);
      hi_ack = pend;
      if (pend) hi_rdata = inst_of(paddr);
      pend  = (hi_req === 1'b1);
      paddr = hi_addr;
    end
  end

  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && o_IFID_valid === 1'b1 && i_IFID_stall === 1'b0) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: pc %h inst %h, none expected (cycle %0d)", o_IFID_pc, o_IFID_inst, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("out_pc", o_IFID_pc, e);
          chk("out_inst", o_IFID_inst, inst_of(e));
        end
      end
    end
  end

  initial begin
    hi_exp[0] = 32'hFFFF_FFF8;
    hi_exp[1] = 32'hFFFF_FFFC;
    hi_exp[2] = 32'h0000_0000;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && hi_valid === 1'b1 && hi_idx < 3) begin
        chk("wrap_pc", hi_pc, hi_exp[hi_idx]);
        chk("wrap_inst", hi_inst, inst_of(hi_exp[hi_idx]));
        hi_idx++;
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: bench did not finish in time (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nvalid;
    rst_n         = 1'b0;
    i_EXIF_jump   = 1'b0;
    i_EXIF_target = '0;
    i_IFID_stall  = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_req", o_imem_req, 1'b0);
    chk("rst_valid", o_IFID_valid, 1'b0);
    chk("rst_pc", o_IFID_pc, 32'h0);
    chk("rst_inst", o_IFID_inst, 32'h0);
    chk("rst_misalign", o_IF_misalign, 1'b0);
    tick();
    rst_n = 1'b1;
    cyc   = 0;

    // Free-running stream: one word every two cycles.
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
    nvalid = 0;
    for (int i = 0; i < 12; i++) begin
      goto(i);
      @(negedge clk);
      if (i == 0) begin
        chk("first_req", o_imem_req, 1'b1);
        chk("first_addr", o_imem_addr, 32'h0);
      end
      if (o_IFID_valid === 1'b1) nvalid++;
    end
    chk("stream_valid_count", 32'(nvalid), 32'd5);

    // Stall for five cycles while the next word lands in the skid.
    exp_q.push_back(32'd20);
    exp_q.push_back(32'd24);
    goto(12);
    i_IFID_stall = 1'b1;
    @(negedge clk);
    chk("stall_valid", o_IFID_valid, 1'b1);
    chk("stall_pc", o_IFID_pc, 32'd20);
    for (int i = 14; i <= 16; i++) begin
      goto(i);
      @(negedge clk);
      chk("full_no_req", o_imem_req, 1'b0);
      chk("full_hold_pc", o_IFID_pc, 32'd20);
      chk("full_hold_inst", o_IFID_inst, inst_of(32'd20));
    end
    goto(17);
    i_IFID_stall = 1'b0;
    goto(18);
    @(negedge clk);
    chk("skid_out_pc", o_IFID_pc, 32'd24);
    chk("post_full_req", o_imem_req, 1'b1);
    chk("post_full_addr", o_imem_addr, 32'd28);

    // Redirect to 0x100 while waiting; the late answer for 32 must be dropped.
    exp_q.push_back(32'd28);
    exp_q.push_back(32'h100);
    goto(19);
    lat = 3;
    goto(21);
    i_EXIF_jump   = 1'b1;
    i_EXIF_target = 32'h100;
    goto(22);
    i_EXIF_jump = 1'b0;
    lat         = 1;
    @(negedge clk);
    chk("kill_valid", o_IFID_valid, 1'b0);
    chk("kill_no_req", o_imem_req, 1'b0);
    goto(23);
    @(negedge clk);
    chk("kill_stale_no_req", o_imem_req, 1'b0);
    goto(24);
    @(negedge clk);
    chk("redir_req", o_imem_req, 1'b1);
    chk("redir_addr", o_imem_addr, 32'h100);
    chk("redir_valid", o_IFID_valid, 1'b0);

    // Misaligned redirect to 0x102 with a same-cycle ack.
`ifndef IF_ALIGN_CHECK_EN
    exp_q.push_back(32'h100);
`endif
    goto(27);
    i_EXIF_jump   = 1'b1;
    i_EXIF_target = 32'h102;
    goto(28);
    i_EXIF_jump = 1'b0;
    @(negedge clk);
    chk("mis_valid", o_IFID_valid, 1'b0);
`ifdef IF_ALIGN_CHECK_EN
    chk("mis_flag", o_IF_misalign, 1'b1);
    chk("mis_no_req", o_imem_req, 1'b0);
    goto(29);
    @(negedge clk);
    chk("halt_flag", o_IF_misalign, 1'b1);
    chk("halt_no_req", o_imem_req, 1'b0);
`else
    chk("mis_flag", o_IF_misalign, 1'b0);
    chk("mis_req", o_imem_req, 1'b1);
    chk("mis_addr", o_imem_addr, 32'h100);
`endif

    // One-cycle reset while waiting; the answer arriving afterwards is ignored.
    exp_q.push_back(32'h0);
    goto(30);
    lat = 2;
    goto(31);
    rst_n = 1'b0;
    goto(32);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rerst_req", o_imem_req, 1'b1);
    chk("rerst_addr", o_imem_addr, 32'h0);
    chk("rerst_valid", o_IFID_valid, 1'b0);
    chk("rerst_misalign", o_IF_misalign, 1'b0);
    goto(33);
    lat = 1;
    @(negedge clk);
    chk("rerst_valid_c33", o_IFID_valid, 1'b0);
    goto(34);
    @(negedge clk);
    chk("rerst_valid_c34", o_IFID_valid, 1'b0);

    // Redirect while stalled in FULL, then fetch across the 32-bit wrap.
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    goto(37);
    i_IFID_stall = 1'b1;
    @(negedge clk);
    chk("f_stall_pc", o_IFID_pc, 32'd4);
    goto(39);
    i_EXIF_jump   = 1'b1;
    i_EXIF_target = 32'hFFFF_FFF8;
    @(negedge clk);
    chk("f_full_no_req", o_imem_req, 1'b0);
    goto(40);
    i_EXIF_jump  = 1'b0;
    i_IFID_stall = 1'b0;
    @(negedge clk);
    chk("f_redir_valid", o_IFID_valid, 1'b0);
    chk("f_redir_addr", o_imem_addr, 32'hFFFF_FFF8);
    goto(44);
    @(negedge clk);
    chk("wrap_req", o_imem_req, 1'b1);
    chk("wrap_addr", o_imem_addr, 32'h0);
    goto(47);
    rst_n = 1'b0;
    goto(49);
    @(negedge clk);
    chk("end_valid", o_IFID_valid, 1'b0);
    chk("end_queue_left", 32'(exp_q.size()), 32'd0);
    chk("hi_seen", 32'(hi_idx), 32'd3);
    chk("hi_misalign", hi_misalign, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
